// File: rtl/led_pkg.sv
// Shared constants and state type for the LED shift-out block.
// Imported by the top and the PWM dimmer.
package led_pkg;
  localparam int LED_W = 16;
  localparam int PWM_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;
endpackage

// File: rtl/led_pwm_dim.sv
// Global brightness dimmer driving the 74HC595 OE# pin.
// Output stays disabled until the first frame has been latched.
module led_pwm_dim
  import led_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PWM_W-1:0] bright,
  output logic             oe_n
);

  logic [PWM_W-1:0] pwm_cnt;

  // free-running duty counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm_cnt <= '0;
    else      pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign oe_n = !(en && (pwm_cnt <= bright));

endmodule

// File: rtl/led_shift_out.sv
// Serialises a debounced LED pattern into two cascaded 74HC595.
// Latest stable pattern wins; running frames are never disturbed.
module led_shift_out #(
  parameter int CLK_DIV = 1,
  parameter int LED_W   = led_pkg::LED_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LED_W-1:0] pat,
  input  logic [2:0]       bright,
  output logic             sr_data,
  output logic             sr_clk,
  output logic             sr_latch,
  output logic             sr_oe_n,
  output logic             busy,
  output logic             dropped
);
  import led_pkg::*;

  localparam int BW = $clog2(LED_W);
  localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(LED_W - 1);

  state_t           state;
  state_t           nxt;
  logic [LED_W-1:0] sync;
  logic [LED_W-1:0] samp;
  logic [LED_W-1:0] prev;
  logic [2:0]       vld;
  logic [LED_W-1:0] pending;
  logic [LED_W-1:0] last_sent;
  logic [LED_W-1:0] shreg;
  logic             pend_vld;
  logic             first;
  logic             oe_en;
  logic [3:0]       div_cnt;
  logic             ph;
  logic [BW-1:0]    bit_cnt;

  logic stable;
  logic wr;
  logic start;
  logic div_end;

  assign stable  = vld[2] && (samp == prev);
  assign wr      = stable && (first || samp != last_sent)
                   && !(pend_vld && samp == pending);
  assign start   = (state == IDLE) && pend_vld;
  assign div_end = (div_cnt == DIV_MAX);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // next state and serial pin decode
  always_comb begin
    nxt      = state;
    sr_data  = 1'b0;
    sr_clk   = 1'b0;
    sr_latch = 1'b0;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_vld) nxt = SHIFT;
      end
      SHIFT: begin
        busy    = 1'b1;
        sr_data = shreg[LED_W-1];
        sr_clk  = ph;
        if (div_end && ph && bit_cnt == LAST_BIT)
          nxt = LATCH;
      end
      LATCH: begin
        busy     = 1'b1;
        sr_latch = 1'b1;
        if (div_end) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // input sampling, pending slot and frame datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync      <= '1;
      samp      <= '1;
      prev      <= '1;
      vld       <= '0;
      pending   <= '1;
      pend_vld  <= 1'b0;
      last_sent <= '1;
      shreg     <= '0;
      first     <= 1'b1;
      oe_en     <= 1'b0;
      dropped   <= 1'b0;
      div_cnt   <= '0;
      ph        <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      sync    <= pat;
      samp    <= sync;
      prev    <= samp;
      vld     <= {vld[1:0], 1'b1};
      dropped <= wr && pend_vld && !start;
      if (wr) begin
        pending  <= samp;
        pend_vld <= 1'b1;
      end else if (start) begin
        pend_vld <= 1'b0;
      end
      if (start) begin
        shreg     <= pending;
        last_sent <= pending;
        first     <= 1'b0;
      end
      if (state == IDLE || div_end) div_cnt <= '0;
      else                          div_cnt <= div_cnt + 1'b1;
      if (state == SHIFT && div_end) begin
        ph <= !ph;
        if (ph) begin
          shreg   <= {shreg[LED_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (state == LATCH && div_end) oe_en <= 1'b1;
    end
  end

  led_pwm_dim u_pwm (
    .clk    (clk),
    .rst    (rst),
    .en     (oe_en),
    .bright (bright),
    .oe_n   (sr_oe_n)
  );

endmodule
